line_decoder_arbiter: RTL and testbench



---
 rtl/line_decoder_arbiter.sv | 144 ++++++++++++++
 tb/tb_line_decoder_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/line_decoder_arbiter.sv
// Round-robin arbiter driving a shared 3-to-8 decoder's Enable/A/B/C, plus a one-hot Grant in decoder bit order.
// Latency: a request sampled at an edge is granted at that edge; every handover inserts one RELEASE gap cycle.
// Backpressure: none; an owner holds until it drops Req (or, with LINE_ARB_BURST_LIMIT_EN, until BURST_MAX cycles with others waiting).
module line_decoder_arbiter #(
    parameter int BURST_MAX = 4
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic [7:0] Req,
    output logic       Enable,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic [7:0] Grant
);

    if (BURST_MAX < 1 || BURST_MAX > 255) begin : g_bad_burst_max
        $error("BURST_MAX must be in 1..255");
    end

    typedef enum logic [1:0] {IDLE, OWN, RELEASE} state_t;

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] owner_q, owner_d;
    logic [2:0] abc_q, abc_d;
    logic       enable_q, enable_d;
    logic [7:0] grant_q, grant_d;
`ifdef LINE_ARB_BURST_LIMIT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       others_vld;
`endif

    logic [7:0] req_by_idx;
    logic       win_vld;
    logic [2:0] win_idx;
    logic       drop_grant;

    // Requester k sits on Req[7-k]; flip once so everything below indexes by requester.
    always_comb begin
        req_by_idx = '0;
        for (int k = 0; k < 8; k++) begin
            req_by_idx[k] = Req[7-k];
        end
    end

    // Scan from the farthest offset down so the nearest request to ptr_q wins.
    always_comb begin
        win_vld = 1'b0;
        win_idx = ptr_q;
        for (int i = 7; i >= 0; i--) begin
            if (req_by_idx[ptr_q + 3'(i)]) begin
                win_vld = 1'b1;
                win_idx = ptr_q + 3'(i);
            end
        end
    end

`ifdef LINE_ARB_BURST_LIMIT_EN
    assign others_vld = |(req_by_idx & ~(8'h01 << owner_q));
`endif

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        abc_d      = abc_q;
        enable_d   = enable_q;
        grant_d    = grant_q;
        drop_grant = 1'b0;
`ifdef LINE_ARB_BURST_LIMIT_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            IDLE, RELEASE: begin
                if (win_vld) begin
                    state_d  = OWN;
                    owner_d  = win_idx;
                    abc_d    = win_idx;
                    enable_d = 1'b1;
                    grant_d  = 8'h80 >> win_idx;
`ifdef LINE_ARB_BURST_LIMIT_EN
                    cnt_d    = 8'd1;
`endif
                end else begin
                    state_d  = IDLE;
                    enable_d = 1'b0;
                    grant_d  = 8'h00;
                end
            end
            OWN: begin
                if (!req_by_idx[owner_q]) begin
                    drop_grant = 1'b1;
`ifdef LINE_ARB_BURST_LIMIT_EN
                end else if (cnt_q == 8'(BURST_MAX) && others_vld) begin
                    drop_grant = 1'b1;
                end else if (cnt_q != 8'(BURST_MAX)) begin
                    cnt_d = cnt_q + 8'd1;
`endif
                end
                if (drop_grant) begin
                    state_d  = RELEASE;
                    ptr_d    = owner_q + 3'd1;
                    enable_d = 1'b0;
                    grant_d  = 8'h00;
                end
            end
            default: begin
                state_d  = IDLE;
                enable_d = 1'b0;
                grant_d  = 8'h00;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q  <= IDLE;
            ptr_q    <= 3'd0;
            owner_q  <= 3'd0;
            abc_q    <= 3'd0;
            enable_q <= 1'b0;
            grant_q  <= 8'h00;
`ifdef LINE_ARB_BURST_LIMIT_EN
            cnt_q    <= 8'd0;
`endif
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            abc_q    <= abc_d;
            enable_q <= enable_d;
            grant_q  <= grant_d;
`ifdef LINE_ARB_BURST_LIMIT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign Enable    = enable_q;
    assign {A, B, C} = abc_q;
    assign Grant     = grant_q;

endmodule

// File: tb/tb_line_decoder_arbiter.sv
// Randomised and directed bench for line_decoder_arbiter against a requester-level model.
module tb_line_decoder_arbiter;

    localparam int BURST_MAX = 4;

    logic       Clock;
    logic       Resetn;
    logic [7:0] Req;
    logic       Enable, A, B, C;
    logic [7:0] Grant;

    int n_tests = 0;
    int n_fail  = 0;

    line_decoder_arbiter #(.BURST_MAX(BURST_MAX)) dut (
        .Clock (Clock),
        .Resetn(Resetn),
        .Req   (Req),
        .Enable(Enable),
        .A     (A),
        .B     (B),
        .C     (C),
        .Grant (Grant)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Model: mode 0 = no owner, 1 = owner holds, 2 = just released (gap cycle).
    int         m_mode, m_ptr, m_owner, m_cnt;
    logic       m_en;
    logic [2:0] m_abc;
    logic [7:0] m_grant;

    task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got {en,abc,grant}=%b_%b_%b expected %b_%b_%b @%0t",
                     tag, got[11], got[10:8], got[7:0], exp[11], exp[10:8], exp[7:0], $time);
        end
    endtask

    function automatic logic [11:0] dut_out();
        return {Enable, A, B, C, Grant};
    endfunction

    task automatic model_edge(input logic [7:0] req, input logic rstn);
        bit r[8];
        int others;
        bit go_release;
        for (int k = 0; k < 8; k++) r[k] = req[7-k];
        if (!rstn) begin
            m_mode = 0; m_ptr = 0; m_owner = 0; m_cnt = 0;
            m_en = 0; m_abc = 0; m_grant = 0;
            return;
        end
        if (m_mode == 1) begin
            others = 0;
            for (int k = 0; k < 8; k++) if (k != m_owner && r[k]) others++;
            go_release = !r[m_owner];
`ifdef LINE_ARB_BURST_LIMIT_EN
            if (!go_release && m_cnt == BURST_MAX && others > 0) go_release = 1;
            else if (!go_release && m_cnt < BURST_MAX) m_cnt++;
`endif
            if (go_release) begin
                m_mode = 2;
                m_ptr = (m_owner + 1) % 8;
                m_en = 0; m_grant = 0;
            end
        end else begin
            int winner = -1;
            for (int i = 0; i < 8 && winner < 0; i++)
                if (r[(m_ptr + i) % 8]) winner = (m_ptr + i) % 8;
            if (winner >= 0) begin
                m_mode = 1; m_owner = winner; m_cnt = 1;
                m_en = 1; m_abc = 3'(winner);
                m_grant = '0;
                m_grant[7 - winner] = 1'b1;
            end else begin
                m_mode = 0; m_en = 0; m_grant = 0;
            end
        end
    endtask

    // Inputs change 1 time unit after the edge, outputs are checked 1 unit after the next edge.
    task automatic step(input logic [7:0] req, input logic rstn, input string tag);
        Req = req;
        Resetn = rstn;
        @(posedge Clock);
        model_edge(req, rstn);
        #1;
        chk(tag, dut_out(), {m_en, m_abc, m_grant});
    endtask

    initial begin
        logic [7:0] rq;
        Req = 8'hFF;
        Resetn = 1'b0;
        #1;

        step(8'hFF, 1'b0, "reset_edge1");
        chk("reset_const1", dut_out(), 12'h000);
        step(8'hFF, 1'b0, "reset_edge2");
        chk("reset_const2", dut_out(), 12'h000);

        step(8'b0100_0000, 1'b1, "single_grant");
        chk("single_const", dut_out(), {1'b1, 3'b001, 8'b0100_0000});
        step(8'h00, 1'b1, "single_drop");
        chk("single_drop_const", dut_out(), {1'b0, 3'b001, 8'h00});
        step(8'h00, 1'b1, "single_idle");

        step(8'h01, 1'b1, "owner7_grant");
        chk("owner7_const", dut_out(), {1'b1, 3'b111, 8'h01});
        step(8'b1000_0010, 1'b1, "wrap_release");
        chk("wrap_release_const", dut_out(), {1'b0, 3'b111, 8'h00});
        step(8'b1000_0010, 1'b1, "wrap_grant");
        chk("wrap_grant_const", dut_out(), {1'b1, 3'b000, 8'h80});

        step(8'b0000_0100, 1'b1, "to5_release");
        step(8'b0000_0100, 1'b1, "to5_grant");
        chk("owner5_const", dut_out(), {1'b1, 3'b101, 8'h04});
        step(8'hFF, 1'b0, "mid_reset");
        chk("mid_reset_const", dut_out(), 12'h000);
        step(8'hFF, 1'b1, "post_reset_grant");
        chk("post_reset_const", dut_out(), {1'b1, 3'b000, 8'h80});

        for (int i = 0; i < 44; i++) step(8'hFF, 1'b1, "burst_all");
`ifndef LINE_ARB_BURST_LIMIT_EN
        chk("hold_owner0_const", dut_out(), {1'b1, 3'b000, 8'h80});
`endif

        step(8'hFF, 1'b0, "idle_ret_reset");
        step(8'b0010_0000, 1'b1, "owner2_grant");
        chk("owner2_const", dut_out(), {1'b1, 3'b010, 8'b0010_0000});
        step(8'h00, 1'b1, "owner2_release");
        chk("owner2_rel_const", dut_out(), {1'b0, 3'b010, 8'h00});
        step(8'h00, 1'b1, "owner2_idle");
        chk("owner2_idle_const", dut_out(), {1'b0, 3'b010, 8'h00});

        rq = 8'h00;
        for (int i = 0; i < 3000; i++) begin
            rq = rq ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            if ($urandom_range(0, 199) == 0) rq = 8'hFF;
            step(rq, ($urandom_range(0, 99) != 0), "random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
